usb_pkt_fifo: RTL

- Synchronous, single-clock, parametrised packet FIFO between the USB SIE and endpoint logic; successor to the fixed 8-bit dual-clock FIFO.
- Write side commits or discards whole packets: an OUT packet with a CRC/PID error is dropped atomically.
- Read side commits or rewinds whole packets: an IN packet is replayed when the host does not ACK.
- One instance per endpoint direction.

---
 rtl/usb_pkt_fifo_pkg.sv | 24 ++
 rtl/usb_pkt_fifo_if.sv | 39 +++
 rtl/usb_pkt_fifo_ram.sv | 50 +++++
 rtl/usb_pkt_fifo.sv | 134 +++++++++++++
 4 files changed

// File: rtl/usb_pkt_fifo_pkg.sv
// Shared types and helpers for the USB packet FIFO.
//   DefaultWidth / DefaultDepth : default data width and storage depth.
//   fifo_status_t               : grouped status flags of one FIFO instance.
//   ptr_diff                    : modulo pointer difference.
// Optional feature macro used by this block: USB_PKT_FIFO_SHOWAHEAD_EN.
package usb_fifo_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDepth = 64;

  typedef struct packed {
    logic wrfull;
    logic rdempty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Modulo difference a - b. Pointers are zero-extended into 32 bits by the caller and the result
  // is cast back to AW+1 bits, which yields the difference modulo 2^(AW+1).
  function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/usb_pkt_fifo_if.sv
// Bus interface of the USB packet FIFO.
//   master : endpoint/SIE side, drives write data, requests and packet controls.
//   slave  : FIFO side, returns read data, fill levels and status flags.
// Write : data, wrreq, wr_commit, wr_discard -> wrfull, wr_used
// Read  : rdreq, rd_commit, rd_rewind        -> q, rdempty, rd_avail
// Sticky: overflow, underflow
// Optional feature macro of the block: USB_PKT_FIFO_SHOWAHEAD_EN (no effect on this file).
interface usb_pkt_fifo_if #(
  parameter int unsigned WIDTH = usb_fifo_pkg::DefaultWidth,
  parameter int unsigned DEPTH = usb_fifo_pkg::DefaultDepth
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] data;
  logic             wrreq;
  logic             wr_commit;
  logic             wr_discard;
  logic             wrfull;
  logic [AW:0]      wr_used;
  logic [WIDTH-1:0] q;
  logic             rdreq;
  logic             rd_commit;
  logic             rd_rewind;
  logic             rdempty;
  logic [AW:0]      rd_avail;
  logic             overflow;
  logic             underflow;

  modport master (
    output data, wrreq, wr_commit, wr_discard, rdreq, rd_commit, rd_rewind,
    input  wrfull, wr_used, q, rdempty, rd_avail, overflow, underflow
  );

  modport slave (
    input  data, wrreq, wr_commit, wr_discard, rdreq, rd_commit, rd_rewind,
    output wrfull, wr_used, q, rdempty, rd_avail, overflow, underflow
  );

endinterface

// File: rtl/usb_pkt_fifo_ram.sv
// Simple dual-port RAM for the USB packet FIFO: one write port, one read port.
// Ports:
//   clk, reset        : clock, synchronous active-high reset (clears the read register only)
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr/o_rdata : read port
// Macro USB_PKT_FIFO_SHOWAHEAD_EN: read port becomes combinational (o_rdata = mem[i_raddr]);
// otherwise o_rdata is registered and updates only when i_re is high.
module usb_fifo_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  // Storage is not reset: after reset every pointer is zero, so no stale word is reachable.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

`ifdef USB_PKT_FIFO_SHOWAHEAD_EN
  logic w_unused;
  assign w_unused = ^{i_re, reset};
  assign o_rdata  = r_mem[i_raddr];
`else
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;
`endif

endmodule

// File: rtl/usb_pkt_fifo.sv
// Single-clock packet FIFO between the USB SIE and endpoint logic.
// Writes are committed or discarded as whole packets; reads are committed or rewound as whole
// packets so an unacknowledged IN packet can be replayed.
// Ports:
//   clk   : clock, all logic on the rising edge
//   reset : synchronous, active-high; clears pointers, flags and q
//   bus   : usb_pkt_fifo_if.slave (data/wrreq/wr_commit/wr_discard, wrfull/wr_used,
//           q/rdreq/rd_commit/rd_rewind, rdempty/rd_avail, overflow/underflow)
// Parameters WIDTH/DEPTH must match those of the connected interface instance.
// Macro USB_PKT_FIFO_SHOWAHEAD_EN: show-ahead read (q = head word whenever not empty, rdreq
// acknowledges it). Default: registered read with one cycle of latency.
module usb_pkt_fifo #(
  parameter int unsigned WIDTH = usb_fifo_pkg::DefaultWidth,
  parameter int unsigned DEPTH = usb_fifo_pkg::DefaultDepth
) (
  input  logic          clk,
  input  logic          reset,
  usb_pkt_fifo_if.slave bus
);
  import usb_fifo_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("usb_pkt_fifo: DEPTH must be a power of 2 and at least 4");
  end

  // Speculative and committed pointers for each side, one extra bit to tell full from empty.
  logic [AW:0] r_wp, r_wp_c, r_rp, r_rp_c;
  logic [AW:0] w_wp_nxt, w_wp_c_nxt, w_rp_nxt, w_rp_c_nxt;
  logic        r_overflow, r_underflow;
  logic        w_overflow_nxt, w_underflow_nxt;

  logic [AW:0]      w_wr_used;
  logic [AW:0]      w_rd_avail;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [WIDTH-1:0] w_ram_rdata;
  fifo_status_t     w_status;

  // Space is counted against the committed read pointer so words read but not yet acknowledged
  // stay protected from overwrite until rd_commit.
  assign w_wr_used  = PW'(ptr_diff(32'(r_wp), 32'(r_rp_c)));
  assign w_rd_avail = PW'(ptr_diff(32'(r_wp_c), 32'(r_rp)));

  always_comb begin
    w_status           = '0;
    w_status.wrfull    = (w_wr_used == PW'(DEPTH));
    w_status.rdempty   = (r_rp == r_wp_c);
    w_status.overflow  = r_overflow;
    w_status.underflow = r_underflow;
  end

  assign w_wr_acc = bus.wrreq && !w_status.wrfull;
  // A rewind takes priority: a read requested in the same cycle is not performed.
  assign w_rd_acc = bus.rdreq && !w_status.rdempty && !bus.rd_rewind;

  always_comb begin
    w_wp_nxt        = r_wp;
    w_wp_c_nxt      = r_wp_c;
    w_rp_nxt        = r_rp;
    w_rp_c_nxt      = r_rp_c;
    w_overflow_nxt  = r_overflow  | (bus.wrreq & w_status.wrfull);
    w_underflow_nxt = r_underflow | (bus.rdreq & w_status.rdempty);

    // Discard beats commit and also drops a word accepted in the same cycle.
    if (bus.wr_discard) begin
      w_wp_nxt = r_wp_c;
    end else begin
      w_wp_nxt = r_wp + PW'(w_wr_acc);
      if (bus.wr_commit) begin
        w_wp_c_nxt = r_wp + PW'(w_wr_acc);
      end
    end

    if (bus.rd_rewind) begin
      w_rp_nxt = r_rp_c;
    end else begin
      w_rp_nxt = r_rp + PW'(w_rd_acc);
      if (bus.rd_commit) begin
        w_rp_c_nxt = r_rp + PW'(w_rd_acc);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp        <= '0;
      r_wp_c      <= '0;
      r_rp        <= '0;
      r_rp_c      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wp        <= w_wp_nxt;
      r_wp_c      <= w_wp_c_nxt;
      r_rp        <= w_rp_nxt;
      r_rp_c      <= w_rp_c_nxt;
      r_overflow  <= w_overflow_nxt;
      r_underflow <= w_underflow_nxt;
    end
  end

  // The written slot is always free (not full), so writing even when discarding is harmless.
  usb_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_wr_acc),
    .i_waddr (r_wp[AW-1:0]),
    .i_wdata (bus.data),
    .i_re    (w_rd_acc),
    .i_raddr (r_rp[AW-1:0]),
    .o_rdata (w_ram_rdata)
  );

`ifdef USB_PKT_FIFO_SHOWAHEAD_EN
  assign bus.q = w_status.rdempty ? '0 : w_ram_rdata;
`else
  assign bus.q = w_ram_rdata;
`endif

  assign bus.wrfull    = w_status.wrfull;
  assign bus.rdempty   = w_status.rdempty;
  assign bus.overflow  = w_status.overflow;
  assign bus.underflow = w_status.underflow;
  assign bus.wr_used   = w_wr_used;
  assign bus.rd_avail  = w_rd_avail;

endmodule
